// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demux dispatcher: channel count,
// channel-index width and the two-state holding-register encoding.
package demux_pkg;

    localparam int NCH = 4;
    localparam int CHW = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: returns the first requesting channel found when
// searching ptr, ptr+1, ... modulo 4. Purely combinational.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [CHW-1:0] gnt_idx,
    output logic           gnt_any
);

    logic [CHW-1:0] idx_w [NCH];
    logic [NCH-1:0] rot_req;

    // Channel index at each search offset; the 2-bit add wraps modulo 4.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
            assign idx_w[gi]   = ptr + CHW'(gi);
            assign rot_req[gi] = req[idx_w[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                gnt_idx = idx_w[i];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Single-producer / four-consumer dispatcher. One output register holds the
// current word until the addressed channel accepts it; a new word can be
// captured in the same cycle the held one leaves, giving one word per cycle.
// Per-channel saturating counters track delivered words.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    output logic              in_ready,
    input  logic [NCH-1:0]    cfg_en,
    input  logic              cfg_fixed,
    input  logic [CHW-1:0]    cfg_chan,
    output logic [NCH-1:0]    out_valid,
    output logic [W-1:0]      out_data,
    input  logic [NCH-1:0]    out_ready,
    output logic [CHW-1:0]    sel,
    output logic [NCH*CW-1:0] cnt
);

    logic [0:0]     state_reg, state_next;
    logic [W-1:0]   data_reg;
    logic [CHW-1:0] sel_reg;
    logic [CHW-1:0] ptr_reg;

    logic [CHW-1:0] rr_idx;
    logic           rr_any;
    logic [CHW-1:0] target;
    logic           have_target;
    logic           busy;
    logic           out_fire;
    logic           capture;

    rr_pick4 u_pick (
        .req     (cfg_en),
        .ptr     (ptr_reg),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Target channel for the next capture: fixed channel if enabled, else RR pick.
    always_comb begin
        target      = rr_idx;
        have_target = rr_any;
        if (cfg_fixed) begin
            target      = cfg_chan;
            have_target = cfg_en[cfg_chan];
        end
    end

    assign busy     = (state_reg == ST_BUSY);
    assign out_fire = busy && out_ready[sel_reg];
    assign in_ready = have_target && (!busy || out_fire);
    assign capture  = in_valid && in_ready;

    // Next state: a capture always leaves the register full; a lone fire empties it.
    always_comb begin
        state_next = state_reg;
        if (capture) begin
            state_next = ST_BUSY;
        end else if (out_fire) begin
            state_next = ST_IDLE;
        end
    end

    // Holding register, channel select and RR pointer; only a capture changes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                data_reg <= in_data;
                sel_reg  <= target;
                if (!cfg_fixed) begin
                    ptr_reg <= target + CHW'(1);
                end
            end
        end
    end

    assign out_data = data_reg;
    assign sel      = sel_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [CW-1:0] cnt_reg;

            assign out_valid[gi]       = busy && (sel_reg == CHW'(gi));
            assign cnt[gi*CW +: CW]    = cnt_reg;

            // Delivered-word counter for this channel, sticking at all-ones.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (out_fire && (sel_reg == CHW'(gi)) && (cnt_reg != {CW{1'b1}})) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Scoreboard bench for demux_rr_dispatcher. Stimulus pushes the hand-computed
// (word, channel) for every captured word; a monitor pops and compares each
// time the DUT delivers a word. Counter width is 2 so saturation is reachable.
module tb_demux_rr_dispatcher;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [3:0]    cfg_en;
    logic          cfg_fixed;
    logic [1:0]    cfg_chan;
    logic [3:0]    out_valid;
    logic [W-1:0]  out_data;
    logic [3:0]    out_ready;
    logic [1:0]    sel;
    logic [4*CW-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W+1:0] exp_q [$];

    demux_rr_dispatcher #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cfg_en    (cfg_en),
        .cfg_fixed (cfg_fixed),
        .cfg_chan  (cfg_chan),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        logic [4*CW-1:0] c;
        c = cnt;
        return 32'(c[k*CW +: CW]);
    endfunction

    // Monitor: every delivered word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && (out_valid != 4'b0000)) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << sel;
            check("onehot", 32'(out_valid), 32'(onehot));
            if (out_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    check("word_data", 32'(out_data), 32'(e[W+1:2]));
                    check("word_sel",  32'(sel),      32'(e[1:0]));
                    $display("deliver data=0x%02h sel=%0d", out_data, sel);
                end
            end
        end
    end

    // Offer one word; expects capture onto channel es within a bounded wait.
    task automatic send(input logic [W-1:0] d, input logic [1:0] es);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back({d, es});
            $display("capture data=0x%02h exp_sel=%0d", d, es);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_en    = 4'hF;
        cfg_fixed = 1'b0;
        cfg_chan  = 2'd0;
        out_ready = 4'hF;
        do_reset();

        // Reset mid-BUSY with a word held on channel 2.
        out_ready = 4'b1011;
        send(8'h01, 2'd0);
        send(8'h02, 2'd1);
        send(8'h03, 2'd2);
        idle(1);
        check("held_before_rst", 32'(out_valid), 32'b0100);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_cnt",       32'(cnt),       32'd0);
        idle(2);
        rst = 1'b0;
        out_ready = 4'hF;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(8'h04, 2'd0);   // ptr was cleared to 0
        idle(2);
        check("post_rst_cnt0", cnt_of(0), 32'd1);

        // RR sweep, back to back.
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 2'(i));
        check("sweep_cycles", 32'(cyc - t0), 32'd8);
        idle(2);
        for (int k = 0; k < 4; k++) check("sweep_cnt", cnt_of(k), 32'd2);
        check("sweep_drained", 32'(exp_q.size()), 32'd0);

        // Skip disabled channels.
        do_reset();
        cfg_en = 4'b1010;
        send(8'h21, 2'd1);
        send(8'h22, 2'd3);
        send(8'h23, 2'd1);
        send(8'h24, 2'd3);
        idle(2);
        check("skip_cnt1", cnt_of(1), 32'd2);
        check("skip_cnt3", cnt_of(3), 32'd2);
        cfg_en   = 4'b0000;
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noen_in_ready",  32'(in_ready),  32'd0);
            check("noen_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_en   = 4'hF;

        // Backpressure on channel 2.
        do_reset();
        out_ready = 4'b1011;
        send(8'h31, 2'd0);
        send(8'h32, 2'd1);
        send(8'hA5, 2'd2);
        out_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_data",     32'(out_data), 32'hA5);
            check("bp_sel",      32'(sel),      32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 4'b0010;
        idle(2);
        check("bp_ignore_other", 32'(out_valid), 32'b0100);
        check("bp_cnt2_held",    cnt_of(2),      32'd0);
        out_ready = 4'b0100;
        idle(1);
        check("bp_fired_valid", 32'(out_valid), 32'd0);
        check("bp_cnt2",        cnt_of(2),      32'd1);
        out_ready = 4'hF;

        // Fixed mode leaves the RR pointer alone.
        do_reset();
        send(8'h40, 2'd0);   // ptr -> 1
        cfg_fixed = 1'b1;
        cfg_chan  = 2'd3;
        send(8'h41, 2'd3);
        send(8'h42, 2'd3);
        send(8'h43, 2'd3);
        cfg_fixed = 1'b0;
        send(8'h44, 2'd1);
        idle(2);
        check("fixed_cnt3", cnt_of(3), 32'd3);
        check("fixed_cnt1", cnt_of(1), 32'd1);

        // Counter saturation on channel 0.
        do_reset();
        cfg_fixed = 1'b1;
        cfg_chan  = 2'd0;
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 2'd0);
        idle(2);
        check("sat_cnt0", cnt_of(0), 32'd3);
        check("sat_drained", 32'(exp_q.size()), 32'd0);
        cfg_fixed = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
